muldiv_ctrl: RTL and testbench

- Iterative multiply/divide controller for the pipelined MIPS EX stage.
- Executes MULT, MULTU, DIV and DIVU over 32 iterations and owns the HI/LO registers.
- Serves MTHI/MTLO writes.
- Raises a stall so the pipeline holds while an operation runs.
- One shared 64-bit shift/add-subtract datapath serves both multiply and divide.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_abs.sv | 23 ++
 rtl/muldiv_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared encodings and constants for the iterative MIPS
//               multiply/divide controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    localparam int          ITER    = 32;
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return ~op[0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_abs.sv
// ============================================================================
// Module      : muldiv_abs
// Description : Combinational magnitude/sign split of one operand.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_signed,
    output logic [W-1:0] o_mag,
    output logic         o_neg
);

    // The most negative value maps onto itself, which is the correct unsigned magnitude.
    assign o_neg = i_signed & i_val[W-1];
    assign o_mag = o_neg ? (~i_val + 1'b1) : i_val;

endmodule

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
// ============================================================================
// Module      : muldiv_ctrl
// Description : 32-iteration MULT/MULTU/DIV/DIVU engine owning HI/LO, with
//               MTHI/MTLO writes and a busy stall for the EX stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            done
);

    localparam int c_CW = $clog2(ITER);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [c_CW-1:0]     r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opd;
    op_e                 r_op;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_div0;
    logic [XLEN-1:0]     r_hi;
    logic [XLEN-1:0]     r_lo;
    logic                r_busy;
    logic                r_done;

    op_e                 w_op_in;
    logic                w_in_signed;
    logic                w_in_div;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_neg_a;
    logic                w_neg_b;
    logic                w_accept;
    logic                w_commit;
    logic                w_mt_en;

    logic                w_is_div;
    logic [XLEN+1:0]     w_x;
    logic [XLEN+1:0]     w_y;
    logic [XLEN+1:0]     w_sum;
    logic [2*XLEN-1:0]   w_acc_step;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_hi_fix;
    logic [XLEN-1:0]     w_lo_fix;

    assign w_op_in     = op_e'(op);
    assign w_in_signed = op_is_signed(w_op_in);
    assign w_in_div    = op_is_div(w_op_in);

    muldiv_abs #(.W(XLEN)) u_abs_a (
        .i_val    (a),
        .i_signed (w_in_signed),
        .o_mag    (w_mag_a),
        .o_neg    (w_neg_a)
    );

    muldiv_abs #(.W(XLEN)) u_abs_b (
        .i_val    (b),
        .i_signed (w_in_signed),
        .o_mag    (w_mag_b),
        .o_neg    (w_neg_b)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (flush)
                    w_state_nxt = S_IDLE;
                else if (r_cnt == c_CW'(ITER - 1))
                    w_state_nxt = S_FIX;
            end
            S_FIX: begin
                w_commit    = ~flush;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_mt_en = (r_state == S_IDLE) && !start;

    // One 34-bit adder: multiply adds the multiplicand to the upper half,
    // divide trial-subtracts the divisor from the left-shifted remainder.
    assign w_is_div = op_is_div(r_op);
    assign w_x      = w_is_div ? {1'b0, r_acc[2*XLEN-1:XLEN-1]} : {2'b00, r_acc[2*XLEN-1:XLEN]};
    assign w_y      = {2'b00, r_opd} ^ {(XLEN+2){w_is_div}};
    assign w_sum    = w_x + w_y + {{(XLEN+1){1'b0}}, w_is_div};

    always_comb begin
        w_acc_step = r_acc;
        if (w_is_div) begin
            if (w_sum[XLEN+1])
                w_acc_step = {r_acc[2*XLEN-2:0], 1'b0};
            else
                w_acc_step = {w_sum[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end else begin
            if (r_acc[0])
                w_acc_step = {w_sum[XLEN:0], r_acc[XLEN-1:1]};
            else
                w_acc_step = {1'b0, r_acc[2*XLEN-1:1]};
        end
    end

    // A zero divisor leaves the dividend magnitude in the remainder half,
    // so re-signing it reproduces the original rs value for HI.
    assign w_prod   = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    assign w_quo    = r_neg_q ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
    assign w_rem    = r_neg_r ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];
    assign w_hi_fix = w_is_div ? w_rem : w_prod[2*XLEN-1:XLEN];
    assign w_lo_fix = w_is_div ? (r_div0 ? DIV0_LO : w_quo) : w_prod[XLEN-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opd   <= '0;
            r_op    <= OP_MULT;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_FIX);

            if (w_accept) begin
                r_cnt   <= '0;
                r_op    <= w_op_in;
                r_acc   <= {{XLEN{1'b0}}, (w_in_div ? w_mag_a : w_mag_b)};
                r_opd   <= w_in_div ? w_mag_b : w_mag_a;
                r_neg_q <= w_neg_a ^ w_neg_b;
                r_neg_r <= w_neg_a;
                r_div0  <= w_in_div && (b == '0);
            end else if (r_state == S_RUN) begin
                r_acc <= w_acc_step;
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_commit) begin
                r_hi <= w_hi_fix;
                r_lo <= w_lo_fix;
            end else if (w_mt_en) begin
                if (mthi) r_hi <= wdata;
                if (mtlo) r_lo <= wdata;
            end
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = r_busy;
    assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Self-checking bench for muldiv_ctrl against an arithmetic
//               reference with a per-cycle compare process.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    muldiv_ctrl #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Reference result {HI, LO} straight from the arithmetic definition.
    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        logic [63:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00:   r = 64'(sx * sy);
            2'b01:   r = {32'h0, x} * {32'h0, y};
            2'b10:   r = (y == 0) ? {x, 32'hFFFF_FFFF} : {32'(sx % sy), 32'(sx / sy)};
            default: r = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
        endcase
        return r;
    endfunction

    // Cycle-level model: an op occupies 33 cycles after the start edge.
    int          m_left = 0;
    logic [63:0] m_res  = '0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0;
            m_hi   = '0;
            m_lo   = '0;
        end else if (m_left == 0) begin
            if (start) begin
                m_res  = ref_res(op, a, b);
                m_left = 33;
            end else begin
                if (mthi) m_hi = wdata;
                if (mtlo) m_lo = wdata;
            end
        end else if (flush) begin
            m_left = 0;
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_hi = m_res[63:32];
                m_lo = m_res[31:0];
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model hi", hi, m_hi);
            check("model lo", lo, m_lo);
            check("model busy", 32'(busy), 32'(m_left != 0));
            check("model done", 32'(done), 32'(m_left == 1));
        end
    end

    // Issue one op at the current negedge and return at the first idle negedge.
    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic fl, input logic mt, input logic [31:0] e_hi, input logic [31:0] e_lo);
        int nb;
        int nd;
        start = 1'b1; op = o; a = x; b = y; flush = fl; mtlo = mt; wdata = 32'h55;
        @(negedge clk);
        start = 1'b0; flush = 1'b0; mtlo = 1'b0;
        nb = 0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) nd++;
            if (!busy) break;
            nb++;
            @(negedge clk);
        end
        check({nm, " busy cycles"}, 32'(nb), 32'd33);
        check({nm, " done pulses"}, 32'(nd), 32'd1);
        check({nm, " hi"}, hi, e_hi);
        check({nm, " lo"}, lo, e_lo);
    endtask

    initial begin
        int nd;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset done", 32'(done), 32'h0);

        run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult -3*7", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mult b2b", 2'b00, 32'h7FFF_FFFF, 32'd2, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFE);
        run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        // flush together with start in IDLE must not cancel the new op
        run_op("divu 7/2", 2'b11, 32'd7, 32'd2, 1'b1, 1'b0, 32'd1, 32'd3);
        run_op("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 32'h8000_0000);
        run_op("divu 5/0", 2'b11, 32'd5, 32'd0, 1'b0, 1'b0, 32'd5, 32'hFFFF_FFFF);
        run_op("div -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

        mthi = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi hi", hi, 32'h1234);
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        for (int c = 1; c <= 11; c++) begin
            if (done) nd++;
            if (c == 10) check("flush busy before", 32'(busy), 32'd1);
            if (c == 11) check("flush busy after", 32'(busy), 32'd0);
            start = (c == 5);
            a = 32'd9; b = 32'd9;
            flush = (c == 10);
            if (c < 11) @(negedge clk);
        end
        start = 1'b0; flush = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("flush hi kept", hi, 32'h1234);
        check("flush done never", 32'(nd), 32'd0);

        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset hi", hi, 32'h0);
        check("midreset lo", lo, 32'h0);
        check("midreset busy", 32'(busy), 32'h0);
        check("midreset done", 32'(done), 32'h0);

        run_op("start+mtlo", 2'b11, 32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 32'd14);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
